// File: rtl/sqrt_hs.sv
// Integer square root, out = floor(sqrt(in)), behind a 4-phase req/fin handshake.
// Restoring radix-2 digit-by-digit recurrence, one result bit per clock.
module sqrt_hs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic             fin,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    localparam int H  = WIDTH / 2;
    localparam int RW = H + 2;
    localparam int CW = $clog2(H + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] rad;
    logic [RW-1:0]    rem, rem_sh, trial, rem_nx;
    logic [H-1:0]     root, root_nx, res;
    logic [CW-1:0]    cnt;
    logic             ge, last;

    // One recurrence step: bring down the next radicand pair and try a 1 digit.
    always_comb begin
        rem_sh  = {rem[RW-3:0], rad[WIDTH-1 -: 2]};
        trial   = {root, 2'b01};
        // Bits shifted out of rem would make rem_sh exceed any trial value.
        ge      = (rem[RW-1 -: 2] != 2'b00) || (rem_sh >= trial);
        rem_nx  = ge ? (rem_sh - trial) : rem_sh;
        root_nx = (root << 1) | H'(ge);
        last    = (cnt == CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = CALC;
            CALC:    if (!req) state_nx = IDLE;
                     else if (last) state_nx = DONE;
            DONE:    if (!req) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad  <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
            res  <= '0;
            fin  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    rad  <= in;
                    rem  <= '0;
                    root <= '0;
                    cnt  <= CW'(H);
                end
                CALC: if (req) begin
                    rad  <= rad << 2;
                    rem  <= rem_nx;
                    root <= root_nx;
                    cnt  <= cnt - CW'(1);
                    if (last) begin
                        res <= root_nx;
                        fin <= 1'b1;
                    end
                end
                DONE: if (!req) fin <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out = {{(WIDTH - H){1'b0}}, res};

endmodule

// File: tb/tb_sqrt_hs.sv
// Self-checking bench for sqrt_hs: directed vector table, handshake corner
// sequences (reset/abort/back-to-back) and random operands against a real-valued model.
module tb_sqrt_hs;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        fin;
    logic [31:0] in;
    logic [31:0] out;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt_hs #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .fin  (fin),
        .in   (in),
        .out  (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic [31:0] e;
    } vec_t;

    function automatic logic [31:0] isqrt(input logic [31:0] v);
        longint r;
        r = longint'($sqrt(real'(v)));
        while (r * r > longint'(v)) r--;
        while ((r + 1) * (r + 1) <= longint'(v)) r++;
        return r[31:0];
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Full handshake; if scramble is set, in is changed every cycle after capture.
    task automatic op(input logic [31:0] v, input logic [31:0] e, input string nm,
                      input bit scramble);
        int  n;
        bit  seen;
        in  = v;
        req = 1'b1;
        @(posedge clk); #1;
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (scramble) in = $urandom;
            @(posedge clk); #1;
            n++;
            if (fin) seen = 1'b1;
        end
        check({nm, " latency"}, 64'(n), 64'd17);
        check({nm, " out"}, 64'(out), 64'(e));
        in  = $urandom;
        req = 1'b0;
        @(posedge clk); #1;
        check({nm, " fin drop"}, 64'(fin), 64'd0);
        check({nm, " out hold"}, 64'(out), 64'(e));
    endtask

    initial begin
        vec_t tbl[10];
        logic [31:0] v, prev;
        bit seen;

        tbl[0] = '{32'd10454520, 32'd3233};
        tbl[1] = '{32'd0, 32'd0};
        tbl[2] = '{32'd1, 32'd1};
        tbl[3] = '{32'd2, 32'd1};
        tbl[4] = '{32'd4, 32'd2};
        tbl[5] = '{32'hFFFFFFFF, 32'd65535};
        tbl[6] = '{32'd4294836225, 32'd65535};
        tbl[7] = '{32'd4294836224, 32'd65534};
        tbl[8] = '{32'd3, 32'd1};
        tbl[9] = '{32'd1000000, 32'd1000};

        rst_n = 1'b0;
        req   = 1'b0;
        in    = '0;
        #3;
        check("reset fin", 64'(fin), 64'd0);
        check("reset out", 64'(out), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle fin", 64'(fin), 64'd0);

        for (int i = 0; i < 10; i++)
            op(tbl[i].v, tbl[i].e, $sformatf("vec%0d", i), 1'b0);

        // Back-to-back with the operand disturbed during CALC.
        op(32'd100, 32'd10, "b2b100", 1'b1);
        op(32'd99, 32'd9, "b2b99", 1'b0);

        // Asynchronous reset at edge 5 of a computation.
        in  = 32'd10454520;
        req = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset fin", 64'(fin), 64'd0);
        check("midreset out", 64'(out), 64'd0);
        req = 1'b0;
        @(posedge clk); #1;
        check("midreset out held", 64'(out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(32'd144, 32'd12, "postreset", 1'b0);

        // Abort by dropping req mid-CALC.
        prev = out;
        in   = 32'd10454520;
        req  = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1 req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (fin) seen = 1'b1;
        end
        check("abort fin", 64'(seen), 64'd0);
        check("abort out", 64'(out), 64'(prev));
        op(32'd625, 32'd25, "postabort", 1'b0);

        // req already high when reset is released.
        rst_n = 1'b0;
        req   = 1'b1;
        in    = 32'd50;
        @(posedge clk);
        #1 rst_n = 1'b1;
        op(32'd50, 32'd7, "reqhigh", 1'b0);

        for (int i = 0; i < 30; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            op(v, isqrt(v), $sformatf("rand%0d(%0d)", i, v), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
